npu_mem_arbiter: RTL and testbench

// - Shares the single-port NPU SRAM between two requesters: host bus (H) and compute engine (E).
// - Sits between the bus interface / engine and the NPU memory port (cen/wen/addr/wdata/rdata).
// - At most one access per cycle. Short locked bursts are supported. Round-robin fairness by default.

---
 rtl/npu_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_npu_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_mem_arbiter.sv
// npu_mem_arbiter
// Shares the single-port NPU SRAM between the host bus (H) and the compute
// engine (E). At most one memory access per cycle. A requester may keep
// ownership for a short locked burst of up to MaxBurst beats. Ties in IDLE
// are broken round-robin.
//
// Build option: define NPU_ARB_HOST_PRIO_EN for fixed host priority on ties.
// Locked bursts and the MaxBurst cap still apply in that build.
//
// Debug: dbg_state_o exposes the FSM state (0=IDLE, 1=OWN_H, 2=OWN_E).
//
// Handshake (identical on the H and E ports):
//   x_req_i is the valid of one beat.
//   x_lock_i, x_wen_i, x_addr_i and x_wdata_i are held stable while
//   x_req_i=1 and x_gnt_o=0.
//   The beat transfers in the cycle where x_req_i && x_gnt_o. That same cycle
//   drives mem_cen_o together with the owner's wen/addr/wdata.
//   x_gnt_o is combinational from the FSM state and the requests.
//   A read granted in cycle N returns x_rvalid_o=1 with x_rdata_o in N+1.
module npu_mem_arbiter #(
  parameter int DWidth   = 32,
  parameter int MaxBurst = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              h_req_i,
  input  logic              h_lock_i,
  input  logic              h_wen_i,
  input  logic [DWidth-1:0] h_addr_i,
  input  logic [DWidth-1:0] h_wdata_i,
  output logic              h_gnt_o,
  output logic              h_rvalid_o,
  output logic [DWidth-1:0] h_rdata_o,
  input  logic              e_req_i,
  input  logic              e_lock_i,
  input  logic              e_wen_i,
  input  logic [DWidth-1:0] e_addr_i,
  input  logic [DWidth-1:0] e_wdata_i,
  output logic              e_gnt_o,
  output logic              e_rvalid_o,
  output logic [DWidth-1:0] e_rdata_o,
  output logic              mem_cen_o,
  output logic              mem_wen_o,
  output logic [DWidth-1:0] mem_addr_o,
  output logic [DWidth-1:0] mem_wdata_o,
  input  logic [DWidth-1:0] mem_rdata_i,
  output logic [1:0]        dbg_state_o
);

  localparam int              CntW    = $clog2(MaxBurst + 1);
  localparam bit              BurstEn = (MaxBurst > 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxBurst);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_H = 2'd1,
    OWN_E = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   burst_q, burst_d, burst_inc;
  logic              gnt_h, gnt_e;
  logic              h_wins_tie;
  logic              h_rvalid_q, e_rvalid_q;
  logic [DWidth-1:0] h_rdata_q, e_rdata_q;

`ifdef NPU_ARB_HOST_PRIO_EN
  // Fixed priority: the host always wins a tie in IDLE.
  assign h_wins_tie = 1'b1;
`else
  // last_e_q remembers the most recent owner. Reset value E lets H win the
  // first tie.
  logic last_e_q;

  // Track the last granted requester. Leaving OWN_x never changes it, because
  // entering OWN_x already recorded x.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_e_q <= 1'b1;
    end else if (gnt_e) begin
      last_e_q <= 1'b1;
    end else if (gnt_h) begin
      last_e_q <= 1'b0;
    end
  end

  assign h_wins_tie = last_e_q;
`endif

  // FSM state register: ownership and burst beat count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Next-state logic. Ownership ends on an unlocked beat, on the capped beat,
  // or when the owner stops requesting.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    burst_inc = burst_q + CntOne;
    unique case (state_q)
      IDLE: begin
        if (gnt_h && h_lock_i && BurstEn) begin
          state_d = OWN_H;
          burst_d = CntOne;
        end else if (gnt_e && e_lock_i && BurstEn) begin
          state_d = OWN_E;
          burst_d = CntOne;
        end
      end
      OWN_H: begin
        if (!h_req_i || !h_lock_i || (burst_inc == CntMax)) begin
          state_d = IDLE;
          burst_d = '0;
        end else begin
          burst_d = burst_inc;
        end
      end
      OWN_E: begin
        if (!e_req_i || !e_lock_i || (burst_inc == CntMax)) begin
          state_d = IDLE;
          burst_d = '0;
        end else begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  // Grant decision and memory port mux. Nothing is granted while reset is held.
  always_comb begin
    gnt_h       = 1'b0;
    gnt_e       = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_ni) begin
      unique case (state_q)
        OWN_H: gnt_h = h_req_i;
        OWN_E: gnt_e = e_req_i;
        default: begin
          if (h_req_i && e_req_i) begin
            gnt_h = h_wins_tie;
            gnt_e = !h_wins_tie;
          end else begin
            gnt_h = h_req_i;
            gnt_e = e_req_i;
          end
        end
      endcase
    end
    if (gnt_h) begin
      mem_wen_o   = h_wen_i;
      mem_addr_o  = h_addr_i;
      mem_wdata_o = h_wdata_i;
    end else if (gnt_e) begin
      mem_wen_o   = e_wen_i;
      mem_addr_o  = e_addr_i;
      mem_wdata_o = e_wdata_i;
    end
    mem_cen_o = gnt_h | gnt_e;
  end

  // Read return path. rvalid follows a granted read by one cycle. The memory
  // data is passed through in that cycle and captured so rdata holds afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_rvalid_q <= 1'b0;
      e_rvalid_q <= 1'b0;
      h_rdata_q  <= '0;
      e_rdata_q  <= '0;
    end else begin
      h_rvalid_q <= gnt_h && !h_wen_i;
      e_rvalid_q <= gnt_e && !e_wen_i;
      if (h_rvalid_q) h_rdata_q <= mem_rdata_i;
      if (e_rvalid_q) e_rdata_q <= mem_rdata_i;
    end
  end

  assign h_gnt_o     = gnt_h;
  assign e_gnt_o     = gnt_e;
  assign h_rvalid_o  = h_rvalid_q;
  assign e_rvalid_o  = e_rvalid_q;
  assign h_rdata_o   = h_rvalid_q ? mem_rdata_i : h_rdata_q;
  assign e_rdata_o   = e_rvalid_q ? mem_rdata_i : e_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Testbench for npu_mem_arbiter.
// A reference model predicts, cycle by cycle, which requester owns the memory.
// The model works from ownership, beats taken and the next tie winner.
// Predicted accesses and read data go into expected queues. A monitor pops
// them whenever the DUT drives the memory port or raises rvalid.
module tb_npu_mem_arbiter;

  localparam int DW        = 32;
  localparam int MAX_BURST = 8;
  localparam int ACC_W     = 2 + 2 * DW;
  localparam int N_RANDOM  = 3000;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_H = 2'd1;

  typedef struct packed {
    logic          req;
    logic          lock;
    logic          wen;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  localparam beat_t IDLE_BEAT = '0;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          h_req = 1'b0, h_lock = 1'b0, h_wen = 1'b0;
  logic [DW-1:0] h_addr = '0, h_wdata = '0;
  logic          e_req = 1'b0, e_lock = 1'b0, e_wen = 1'b0;
  logic [DW-1:0] e_addr = '0, e_wdata = '0;
  logic          h_gnt_o, h_rvalid_o, e_gnt_o, e_rvalid_o;
  logic [DW-1:0] h_rdata_o, e_rdata_o;
  logic          mem_cen_o, mem_wen_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o;
  logic [1:0]    dbg_state_o;

  // Behavioural single-port SRAM, read data one cycle after access.
  logic [DW-1:0] sram [16] = '{default: '0};
  logic [DW-1:0] mem_rdata = '0;

  npu_mem_arbiter #(.DWidth(DW), .MaxBurst(MAX_BURST)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .h_req_i(h_req), .h_lock_i(h_lock), .h_wen_i(h_wen),
    .h_addr_i(h_addr), .h_wdata_i(h_wdata),
    .h_gnt_o(h_gnt_o), .h_rvalid_o(h_rvalid_o), .h_rdata_o(h_rdata_o),
    .e_req_i(e_req), .e_lock_i(e_lock), .e_wen_i(e_wen),
    .e_addr_i(e_addr), .e_wdata_i(e_wdata),
    .e_gnt_o(e_gnt_o), .e_rvalid_o(e_rvalid_o), .e_rdata_o(e_rdata_o),
    .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .dbg_state_o(dbg_state_o)
  );

  always @(posedge clk) begin
    if (mem_cen_o) begin
      if (mem_wen_o) sram[mem_addr_o[5:2]] <= mem_wdata_o;
      else           mem_rdata <= sram[mem_addr_o[5:2]];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [ACC_W-1:0] acc_q[$];
  logic [DW-1:0]    h_rd_q[$];
  logic [DW-1:0]    e_rd_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [ACC_W-1:0] act,
                                input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  // owner: 0 none, 1 H, 2 E.  tie_winner: who takes the next IDLE tie (1 H, 2 E).
  int owner = 0;
  int beats = 0;
  int tie_winner = 1;
  logic [DW-1:0] ref_mem [16] = '{default: '0};
  beat_t h_cur = '0;
  beat_t e_cur = '0;
  logic  rst_next = 1'b0;
  logic  gh, ge;

  task automatic record(input logic is_e, input beat_t b);
    logic [3:0] idx;
    idx = b.addr[5:2];
    acc_q.push_back({is_e, b.wen, b.addr, b.wdata});
    if (b.wen) ref_mem[idx] = b.wdata;
    else if (is_e) e_rd_q.push_back(ref_mem[idx]);
    else h_rd_q.push_back(ref_mem[idx]);
  endtask

  task automatic model_cycle(output logic pg_h, output logic pg_e);
    pg_h = 1'b0;
    pg_e = 1'b0;
    if (!rst_next) begin
      owner = 0;
      beats = 0;
      tie_winner = 1;
      return;
    end
    if (owner == 1) begin
      if (h_cur.req) begin
        pg_h = 1'b1;
        beats++;
        if (!h_cur.lock || beats == MAX_BURST) owner = 0;
      end else begin
        owner = 0;
      end
      if (owner == 0) tie_winner = 2;
    end else if (owner == 2) begin
      if (e_cur.req) begin
        pg_e = 1'b1;
        beats++;
        if (!e_cur.lock || beats == MAX_BURST) owner = 0;
      end else begin
        owner = 0;
      end
      if (owner == 0) tie_winner = 1;
    end else begin
      if (h_cur.req && e_cur.req) begin
`ifdef NPU_ARB_HOST_PRIO_EN
        pg_h = 1'b1;
`else
        pg_h = (tie_winner == 1);
`endif
        pg_e = !pg_h;
      end else begin
        pg_h = h_cur.req;
        pg_e = e_cur.req;
      end
      if (pg_h) begin
        tie_winner = 2;
        if (h_cur.lock && MAX_BURST > 1) begin owner = 1; beats = 1; end
      end
      if (pg_e) begin
        tie_winner = 1;
        if (e_cur.lock && MAX_BURST > 1) begin owner = 2; beats = 1; end
      end
    end
    if (pg_h) record(1'b0, h_cur);
    if (pg_e) record(1'b1, e_cur);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(output logic pg_h, output logic pg_e);
    @(posedge clk);
    #1;
    rst_n   = rst_next;
    h_req   = h_cur.req;  h_lock = h_cur.lock; h_wen = h_cur.wen;
    h_addr  = h_cur.addr; h_wdata = h_cur.wdata;
    e_req   = e_cur.req;  e_lock = e_cur.lock; e_wen = e_cur.wen;
    e_addr  = e_cur.addr; e_wdata = e_cur.wdata;
    model_cycle(pg_h, pg_e);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    logic a, b;
    h_cur = IDLE_BEAT;
    e_cur = IDLE_BEAT;
    repeat (n) step(a, b);
  endtask

  function automatic beat_t mk(input logic lock, input logic wen,
                               input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
    beat_t b;
    b.req = 1'b1; b.lock = lock; b.wen = wen; b.addr = addr; b.wdata = wdata;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.req   = ($urandom_range(0, 3) != 0);
    b.lock  = ($urandom_range(0, 3) != 0);
    b.wen   = 1'($urandom_range(0, 1));
    b.addr  = DW'($urandom_range(0, 15)) << 2;
    b.wdata = $urandom;
    return b;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("one_gnt", ACC_W'(h_gnt_o & e_gnt_o), ACC_W'(0));
    check("cen_vs_gnt", ACC_W'(mem_cen_o), ACC_W'(h_gnt_o | e_gnt_o));
    if (mem_cen_o === 1'b1) begin
      if (acc_q.size() == 0) begin
        n_checks++;
        $display("FAIL acc_unexpected: got access addr 0x%0h, expected none (t=%0t)",
                 mem_addr_o, $time);
      end else begin
        check("mem_access", {e_gnt_o, mem_wen_o, mem_addr_o, mem_wdata_o}, acc_q.pop_front());
      end
    end
    if (h_rvalid_o === 1'b1) begin
      if (h_rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL h_rvalid_unexpected: got 0x%0h, expected none (t=%0t)", h_rdata_o, $time);
      end else begin
        check("h_rdata", ACC_W'(h_rdata_o), ACC_W'(h_rd_q.pop_front()));
      end
    end
    if (e_rvalid_o === 1'b1) begin
      if (e_rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL e_rvalid_unexpected: got 0x%0h, expected none (t=%0t)", e_rdata_o, $time);
      end else begin
        check("e_rdata", ACC_W'(e_rdata_o), ACC_W'(e_rd_q.pop_front()));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hb, eb;
    logic done;

    // Reset with both requesting.
    rst_next = 1'b0;
    h_cur = mk(1'b0, 1'b0, 32'h0, 32'h0);
    e_cur = mk(1'b0, 1'b0, 32'h8, 32'h0);
    step(gh, ge);
    step(gh, ge);
    check("rst_h_gnt", ACC_W'(h_gnt_o), ACC_W'(0));
    check("rst_e_gnt", ACC_W'(e_gnt_o), ACC_W'(0));
    check("rst_cen", ACC_W'(mem_cen_o), ACC_W'(0));
    check("rst_h_rvalid", ACC_W'(h_rvalid_o), ACC_W'(0));
    check("rst_e_rvalid", ACC_W'(e_rvalid_o), ACC_W'(0));
    rst_next = 1'b1;

    // Single write then read by the host.
    h_cur = mk(1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
    e_cur = IDLE_BEAT;
    step(gh, ge);
    check("wr_h_gnt", ACC_W'(h_gnt_o), ACC_W'(1));
    check("wr_mem_wen", ACC_W'(mem_wen_o), ACC_W'(1));
    check("wr_mem_addr", ACC_W'(mem_addr_o), ACC_W'(32'h4));
    h_cur = mk(1'b0, 1'b0, 32'h4, 32'h0);
    step(gh, ge);
    check("rd_h_gnt", ACC_W'(h_gnt_o), ACC_W'(1));
    check("rd_mem_wen", ACC_W'(mem_wen_o), ACC_W'(0));
    h_cur = IDLE_BEAT;
    step(gh, ge);
    check("rd_h_rvalid", ACC_W'(h_rvalid_o), ACC_W'(1));
    check("rd_h_rdata", ACC_W'(h_rdata_o), ACC_W'(32'hDEADBEEF));
    check("rd_e_rvalid", ACC_W'(e_rvalid_o), ACC_W'(0));
    check("idle_cen", ACC_W'(mem_cen_o), ACC_W'(0));
    step(gh, ge);
    check("rd_hold_rvalid", ACC_W'(h_rvalid_o), ACC_W'(0));
    check("rd_hold_rdata", ACC_W'(h_rdata_o), ACC_W'(32'hDEADBEEF));

    // Tie: fresh reset, then both request unlocked reads for 4 cycles.
    rst_next = 1'b0;
    idle_cycles(2);
    rst_next = 1'b1;
    h_cur = mk(1'b0, 1'b0, 32'h10, 32'h0);
    e_cur = mk(1'b0, 1'b0, 32'h14, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step(gh, ge);
`ifdef NPU_ARB_HOST_PRIO_EN
      check("tie_h_gnt", ACC_W'(h_gnt_o), ACC_W'(1));
`else
      check("tie_h_gnt", ACC_W'(h_gnt_o), ACC_W'((c % 2) == 0));
`endif
      if (gh) h_cur = mk(1'b0, 1'b0, DW'(c + 5) << 2, 32'h0);
      if (ge) e_cur = mk(1'b0, 1'b0, DW'(c + 9) << 2, 32'h0);
    end
    idle_cycles(3);

    // Burst cap: E locks for 10 beats, H joins from cycle 2 with one beat.
    eb = 0;
    done = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      e_cur = (eb < 10) ? mk(eb < 9, 1'b1, DW'(eb) << 2, 32'hE000_0000 + DW'(eb)) : IDLE_BEAT;
      h_cur = (c >= 2 && !done) ? mk(1'b0, 1'b0, 32'h3C, 32'h0) : IDLE_BEAT;
      step(gh, ge);
      if (c <= MAX_BURST + 2) check("cap_e_gnt", ACC_W'(e_gnt_o), ACC_W'(c != MAX_BURST + 1));
      if (c == MAX_BURST + 1) check("cap_h_gnt", ACC_W'(h_gnt_o), ACC_W'(1));
      if (ge) eb++;
      if (gh) done = 1'b1;
    end
    idle_cycles(3);

    // Lock release: H locks 3 beats, unlocks on the 4th, E waits.
    hb = 0;
    done = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      h_cur = (hb < 4) ? mk(hb < 3, 1'b1, DW'(8 + hb) << 2, 32'hA000_0000 + DW'(hb)) : IDLE_BEAT;
      e_cur = !done ? mk(1'b0, 1'b0, 32'h4, 32'h0) : IDLE_BEAT;
      step(gh, ge);
      if (c <= 4) check("rel_h_gnt", ACC_W'(h_gnt_o), ACC_W'(1));
      if (c == 2) check("rel_state_own", ACC_W'(dbg_state_o), ACC_W'(ST_OWN_H));
      if (c == 5) begin
        check("rel_e_gnt", ACC_W'(e_gnt_o), ACC_W'(1));
        check("rel_state_idle", ACC_W'(dbg_state_o), ACC_W'(ST_IDLE));
      end
      if (gh) hb++;
      if (ge) done = 1'b1;
    end
    idle_cycles(3);

    // Reset in the middle of a locked E read burst.
    h_cur = IDLE_BEAT;
    for (int c = 0; c < 2; c++) begin
      e_cur = mk(1'b1, 1'b0, DW'(c) << 2, 32'h0);
      step(gh, ge);
      check("mid_e_gnt", ACC_W'(e_gnt_o), ACC_W'(1));
    end
    e_cur = mk(1'b1, 1'b0, 32'h8, 32'h0);
    rst_next = 1'b0;
    step(gh, ge);
    check("mid_rst_e_gnt", ACC_W'(e_gnt_o), ACC_W'(0));
    rst_next = 1'b1;
    h_cur = mk(1'b0, 1'b0, 32'h20, 32'h0);
    step(gh, ge);
    check("post_rst_state", ACC_W'(dbg_state_o), ACC_W'(ST_IDLE));
    check("post_rst_e_rvalid", ACC_W'(e_rvalid_o), ACC_W'(0));
    check("post_rst_h_gnt", ACC_W'(h_gnt_o), ACC_W'(1));
    h_cur = IDLE_BEAT;
    step(gh, ge);
    if (ge) e_cur = IDLE_BEAT;
    idle_cycles(3);

    // Randomised traffic with occasional resets.
    h_cur = rand_beat();
    e_cur = rand_beat();
    for (int c = 0; c < N_RANDOM; c++) begin
      rst_next = ($urandom_range(0, 299) != 0);
      step(gh, ge);
      if (gh || !h_cur.req) h_cur = rand_beat();
      if (ge || !e_cur.req) e_cur = rand_beat();
    end
    rst_next = 1'b1;
    idle_cycles(4);

    check("acc_q_drained", ACC_W'(acc_q.size()), ACC_W'(0));
    check("h_rd_q_drained", ACC_W'(h_rd_q.size()), ACC_W'(0));
    check("e_rd_q_drained", ACC_W'(e_rd_q.size()), ACC_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
